mse_accumulator: RTL

//  Computes squared-error sums between a reference FIR output and NUM_DUT

---
 rtl/fir_mse_pkg.sv | 40 ++++
 rtl/mse_sq_pipe.sv | 69 ++++++
 rtl/mse_accumulator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fir_mse_pkg.sv
// Shared types and helpers for the FIR squared-error accumulator.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: none; nothing here carries flow control.
package fir_mse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mse_state_t;

  localparam int ACC_W_DEF  = 64;
  localparam int DATA_W_DEF = 24;

  // Widest accumulator the saturating adder supports.
  localparam int SAT_MAX_W = 128;
  localparam logic [SAT_MAX_W:0] SAT_ONE = {{SAT_MAX_W{1'b0}}, 1'b1};

  // Last DRAIN cycle index: DRAIN lasts cycles 0,1,2 while the pipe empties.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  // Unsigned add that clamps at 2^acc_w-1 instead of wrapping. Operands are
  // zero-extended to SAT_MAX_W by the caller; acc_w must be <= SAT_MAX_W.
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W-1:0] acc,
    input logic [SAT_MAX_W-1:0] sq,
    input int                   acc_w
  );
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sum = {1'b0, acc} + {1'b0, sq};
    lim = (SAT_ONE << acc_w) - SAT_ONE;
    if (sum > lim) begin
      return lim[SAT_MAX_W-1:0];
    end
    return sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/mse_sq_pipe.sv
// Difference and square stages (S1/S2) for one DUT channel.
// Latency: 2 cycles from vld_i to sq_vld_o; a valid bit travels with the data.
// Backpressure: none; accepts every strobe, soft reset flushes in-flight data.
module mse_sq_pipe #(
  parameter int DATA_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rstn_i,
  input  logic                  vld_i,
  input  logic [DATA_W-1:0]     ref_i,
  input  logic [DATA_W-1:0]     dut_i,
  output logic [2*DATA_W+1:0]   sq_o,
  output logic                  sq_vld_o
);

  localparam int SQ_W = 2*DATA_W+2;

  logic signed [DATA_W:0] diff_d, diff_q;
  logic                   v1_q;
  logic signed [SQ_W-1:0] diff_ext;
  logic signed [SQ_W-1:0] prod_d;
  logic [SQ_W-1:0]        sq_q;
  logic                   v2_q;

  // One extra bit keeps the full-scale difference exact; the square of that
  // fits in SQ_W as a non-negative signed value, so its bits are the unsigned sq.
  always_comb begin
    diff_d   = $signed({dut_i[DATA_W-1], dut_i}) - $signed({ref_i[DATA_W-1], ref_i});
    diff_ext = SQ_W'(diff_q);
    prod_d   = diff_ext * diff_ext;
  end

  // S1: register the signed difference and its valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q <= '0;
      v1_q   <= 1'b0;
    end else if (!soft_rstn_i) begin
      diff_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= vld_i;
      if (vld_i) begin
        diff_q <= diff_d;
      end
    end
  end

  // S2: register the square and its valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_q <= '0;
      v2_q <= 1'b0;
    end else if (!soft_rstn_i) begin
      sq_q <= '0;
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        sq_q <= $unsigned(prod_d);
      end
    end
  end

  assign sq_o     = sq_q;
  assign sq_vld_o = v2_q;

endmodule

// File: rtl/mse_accumulator.sv
// Sums squared error between a reference FIR and NUM_DUT reduced FIRs per run.
// Latency: last sample accepted at cycle T -> mse_valid pulse at T+4.
// Backpressure: none; in_valid ignored outside RUN, start ignored outside IDLE.
module mse_accumulator
  import fir_mse_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_DUT     = 2,
  parameter int NUM_SAMPLES = 4096,
  parameter int ACC_W       = ACC_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             soft_rstn,
  input  logic                             start,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                ref_data,
  input  logic [NUM_DUT-1:0][DATA_W-1:0]   dut_data,
  output logic [NUM_DUT-1:0][ACC_W-1:0]    mse_data,
  output logic                             mse_valid,
  output logic                             busy
);

  localparam int          SQ_W     = 2*DATA_W+2;
  localparam logic [31:0] CNT_LAST = 32'(NUM_SAMPLES-1);

  mse_state_t                     state_q, state_d;
  logic [31:0]                    cnt_q, cnt_d;
  logic [1:0]                     drain_q, drain_d;
  logic [NUM_DUT-1:0][ACC_W-1:0]  acc_q, acc_d;
  logic [NUM_DUT-1:0][ACC_W-1:0]  mse_q, mse_d;

  logic                           accept;
  logic [NUM_DUT-1:0][SQ_W-1:0]   sq;
  logic [NUM_DUT-1:0]             sq_vld;
  logic [SAT_MAX_W-1:0]           sum_w [NUM_DUT];

  assign accept = (state_q == RUN) && in_valid;

  genvar g;
  generate
    for (g = 0; g < NUM_DUT; g++) begin : g_ch
      mse_sq_pipe #(
        .DATA_W (DATA_W)
      ) u_sq_pipe (
        .clk         (clk),
        .rst         (rst),
        .soft_rstn_i (soft_rstn),
        .vld_i       (accept),
        .ref_i       (ref_data),
        .dut_i       (dut_data[g]),
        .sq_o        (sq[g]),
        .sq_vld_o    (sq_vld[g])
      );
    end
  endgenerate

  // Next-state: S3 accumulation, run sequencing, and soft abort override.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    acc_d   = acc_q;
    mse_d   = mse_q;
    for (int i = 0; i < NUM_DUT; i++) begin
      sum_w[i] = '0;
    end

    // S3: squares only arrive after a run's samples, so this never collides
    // with the clear on start below.
    for (int i = 0; i < NUM_DUT; i++) begin
      sum_w[i] = sat_add(SAT_MAX_W'(acc_q[i]), SAT_MAX_W'(sq[i]), ACC_W);
      if (sq_vld[i]) begin
        acc_d[i] = sum_w[i][ACC_W-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        // By the last DRAIN cycle the final square has landed in acc_q.
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
          mse_d   = acc_q;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Soft abort beats start and in_valid arriving in the same cycle.
    if (!soft_rstn) begin
      state_d = IDLE;
      cnt_d   = '0;
      drain_d = '0;
      acc_d   = '0;
      mse_d   = '0;
    end
  end

  // State, counters, accumulators and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      acc_q   <= '0;
      mse_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      acc_q   <= acc_d;
      mse_q   <= mse_d;
    end
  end

  // mse_data is loaded on entry to DONE so data and strobe line up; a soft
  // abort during DONE suppresses the strobe.
  assign mse_data  = mse_q;
  assign mse_valid = (state_q == DONE) && soft_rstn;
  assign busy      = (state_q != IDLE);

endmodule
